// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage with EX/MEM pipeline register
//
// Ports:
//   clock, rst            rising-edge clock, synchronous active-high reset
//   stall, bubble         hold / null-load control for the EX/MEM register
//   *_i                   decoded operands and controls from ID/EX
//   privilege             1 = supervisor mode
//   enable_tlb_write_o,
//   virtual_page_o,
//   phys_page_o           combinational TLB write command
//   pcSrc, pcBranch       registered fetch redirect
//   alu_result ... exception  registered EX/MEM contents for the memory stage
module exec_stage #(
  parameter int OFFSET = 12
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                stall,
  input  logic                bubble,
  input  logic                valid_i,
  input  logic [31:0]         pc_plus4_i,
  input  logic [31:0]         reg_a_i,
  input  logic [31:0]         reg_b_i,
  input  logic [31:0]         imm_i,
  input  logic [31:0]         jump_target_i,
  input  logic [4:0]          rd_i,
  input  logic [2:0]          alu_op_i,
  input  logic                alu_src_i,
  input  logic                branch_i,
  input  logic                jump_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic                reg_write_i,
  input  logic                mem_to_reg_i,
  input  logic                tlbwrite_i,
  input  logic                iret_i,
  input  logic                privilege,
  output logic                enable_tlb_write_o,
  output logic [31-OFFSET:0]  virtual_page_o,
  output logic [31-OFFSET:0]  phys_page_o,
  output logic                pcSrc,
  output logic [31:0]         pcBranch,
  output logic [31:0]         alu_result,
  output logic [31:0]         write_data,
  output logic [4:0]          rd,
  output logic                valid,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                exception
);

  logic [31:0] op_b;
  logic [31:0] alu_next;
  logic [31:0] branch_target;
  logic [31:0] redirect_target;
  logic        viol;
  logic        taken;

  assign op_b = alu_src_i ? imm_i : reg_b_i;

  always_comb begin
    alu_next = 32'd0;
    case (alu_op_i)
      3'b000:  alu_next = reg_a_i + op_b;
      3'b001:  alu_next = reg_a_i - op_b;
      3'b010:  alu_next = reg_a_i & op_b;
      3'b011:  alu_next = reg_a_i | op_b;
      3'b100:  alu_next = reg_a_i ^ op_b;
      3'b101:  alu_next = {31'd0, $signed(reg_a_i) < $signed(op_b)};
      3'b110:  alu_next = reg_a_i << op_b[4:0];
      default: alu_next = reg_a_i * op_b;
    endcase
  end

  assign branch_target   = pc_plus4_i + (imm_i << 2);
  assign redirect_target = jump_i ? jump_target_i : branch_target;

  // User-mode privileged instructions are squashed: no redirect, no side effects.
  assign viol  = valid_i & ~privilege & (tlbwrite_i | iret_i);
  // Branch compare uses the raw register operands, not the B-mux output.
  assign taken = valid_i & ~viol & (jump_i | (branch_i & (reg_a_i == reg_b_i)));

  // Suppressed while stalled so a held tlbwrite is issued exactly once.
  assign enable_tlb_write_o = valid_i & tlbwrite_i & privilege & ~stall;
  assign virtual_page_o     = reg_a_i[31:OFFSET];
  assign phys_page_o        = reg_b_i[31:OFFSET];

  always_ff @(posedge clock) begin
    if (rst || (!stall && bubble)) begin
      valid      <= 1'b0;
      pcSrc      <= 1'b0;
      pcBranch   <= 32'd0;
      alu_result <= 32'd0;
      write_data <= 32'd0;
      rd         <= 5'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      exception  <= 1'b0;
    end else if (!stall) begin
      valid      <= valid_i;
      pcSrc      <= taken;
      pcBranch   <= redirect_target;
      alu_result <= alu_next;
      write_data <= reg_b_i;
      rd         <= rd_i;
      mem_read   <= valid_i & ~viol & mem_read_i;
      mem_write  <= valid_i & ~viol & mem_write_i;
      reg_write  <= valid_i & ~viol & reg_write_i;
      mem_to_reg <= valid_i & mem_to_reg_i;
      exception  <= viol;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - randomized self-checking bench for exec_stage
module tb_exec_stage;

  logic        clock = 1'b0;
  logic        rst, stall, bubble, valid_i;
  logic [31:0] pc_plus4_i, reg_a_i, reg_b_i, imm_i, jump_target_i;
  logic [4:0]  rd_i;
  logic [2:0]  alu_op_i;
  logic        alu_src_i, branch_i, jump_i, mem_read_i, mem_write_i;
  logic        reg_write_i, mem_to_reg_i, tlbwrite_i, iret_i, privilege;
  logic        enable_tlb_write_o;
  logic [19:0] virtual_page_o, phys_page_o;
  logic        pcSrc;
  logic [31:0] pcBranch, alu_result, write_data;
  logic [4:0]  rd;
  logic        valid, mem_read, mem_write, reg_write, mem_to_reg, exception;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        exception;
  } exmem_t;

  exmem_t exp_q;
  exmem_t got;

  exec_stage #(.OFFSET(12)) dut (
    .clock(clock), .rst(rst), .stall(stall), .bubble(bubble), .valid_i(valid_i),
    .pc_plus4_i(pc_plus4_i), .reg_a_i(reg_a_i), .reg_b_i(reg_b_i), .imm_i(imm_i),
    .jump_target_i(jump_target_i), .rd_i(rd_i), .alu_op_i(alu_op_i),
    .alu_src_i(alu_src_i), .branch_i(branch_i), .jump_i(jump_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .mem_to_reg_i(mem_to_reg_i), .tlbwrite_i(tlbwrite_i), .iret_i(iret_i),
    .privilege(privilege), .enable_tlb_write_o(enable_tlb_write_o),
    .virtual_page_o(virtual_page_o), .phys_page_o(phys_page_o), .pcSrc(pcSrc),
    .pcBranch(pcBranch), .alu_result(alu_result), .write_data(write_data), .rd(rd),
    .valid(valid), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .exception(exception)
  );

  always #5 clock = ~clock;

  assign got = '{valid, pcSrc, pcBranch, alu_result, write_data, rd,
                 mem_read, mem_write, reg_write, mem_to_reg, exception};

  // Reference: what the EX/MEM register should hold after the next edge.
  function automatic exmem_t model_next(exmem_t cur);
    exmem_t n;
    logic [31:0] b;
    logic        user_priv;
    logic        go;
    if (rst) return '0;
    if (stall) return cur;
    if (bubble) return '0;
    b = alu_src_i ? imm_i : reg_b_i;
    case (alu_op_i)
      3'd0: n.alu_result = reg_a_i + b;
      3'd1: n.alu_result = reg_a_i - b;
      3'd2: n.alu_result = reg_a_i & b;
      3'd3: n.alu_result = reg_a_i | b;
      3'd4: n.alu_result = reg_a_i ^ b;
      3'd5: n.alu_result = (int'(reg_a_i) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: n.alu_result = reg_a_i * (32'd1 << b[4:0]);
      default: n.alu_result = reg_a_i * b;
    endcase
    user_priv = valid_i && !privilege && (tlbwrite_i || iret_i);
    go = valid_i && !user_priv;
    n.valid      = valid_i;
    n.pc_src     = go && (jump_i || (branch_i && reg_a_i == reg_b_i));
    n.pc_branch  = jump_i ? jump_target_i : pc_plus4_i + imm_i * 4;
    n.write_data = reg_b_i;
    n.rd         = rd_i;
    n.mem_read   = go && mem_read_i;
    n.mem_write  = go && mem_write_i;
    n.reg_write  = go && reg_write_i;
    n.mem_to_reg = valid_i && mem_to_reg_i;
    n.exception  = user_priv;
    return n;
  endfunction

  task automatic tick();
    exp_q = model_next(exp_q);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    {valid_i, alu_src_i, branch_i, jump_i, mem_read_i, mem_write_i} = '0;
    {reg_write_i, mem_to_reg_i, tlbwrite_i, iret_i, privilege} = '0;
    {pc_plus4_i, reg_a_i, reg_b_i, imm_i, jump_target_i} = '0;
    rd_i = '0;
    alu_op_i = '0;
  endtask

  task automatic random_inputs();
    valid_i = 1'($urandom);     pc_plus4_i = $urandom;  reg_a_i = $urandom;
    reg_b_i = $urandom;         imm_i = $urandom;       jump_target_i = $urandom;
    rd_i = 5'($urandom);        alu_op_i = 3'($urandom); alu_src_i = 1'($urandom);
    branch_i = 1'($urandom);    jump_i = ($urandom_range(0, 3) == 0);
    mem_read_i = 1'($urandom);  mem_write_i = 1'($urandom);
    reg_write_i = 1'($urandom); mem_to_reg_i = 1'($urandom);
    tlbwrite_i = ($urandom_range(0, 3) == 0); iret_i = ($urandom_range(0, 3) == 0);
    privilege = 1'($urandom);
    if ($urandom_range(0, 3) == 0) reg_b_i = reg_a_i;
    if ($urandom_range(0, 3) == 0) imm_i = 32'($signed(5'($urandom)));
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'($urandom); bubble = 1'($urandom);
    random_inputs();
    tick();
    random_inputs();
    tick();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  task automatic test_add();
    clear_inputs();
    valid_i = 1'b1; reg_a_i = 32'h7FFF_FFFF; imm_i = 32'd1; alu_src_i = 1'b1;
    rd_i = 5'd5; reg_write_i = 1'b1; alu_op_i = 3'b000;
    tick();
    checks++;
    if (alu_result !== 32'h8000_0000 || rd !== 5'd5 || reg_write !== 1'b1 || exception !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap alu=%h rd=%0d rw=%b exc=%b exp alu=80000000 rd=5 rw=1 exc=0",
               alu_result, rd, reg_write, exception);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    valid_i = 1'b1; branch_i = 1'b1; reg_a_i = 32'd3; reg_b_i = 32'd3;
    pc_plus4_i = 32'h100; imm_i = 32'd4;
    tick();
    checks++;
    if (pcSrc !== 1'b1 || pcBranch !== 32'h110) begin
      errors++;
      $display("FAIL beq_taken pcSrc=%b pcBranch=%h exp 1 00000110", pcSrc, pcBranch);
    end
    reg_b_i = 32'd4;
    tick();
    checks++;
    if (pcSrc !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_taken pcSrc=%b exp 0", pcSrc);
    end
  endtask

  task automatic test_tlb();
    clear_inputs();
    valid_i = 1'b1; tlbwrite_i = 1'b1; privilege = 1'b1;
    reg_a_i = 32'h0040_3000; reg_b_i = 32'h0000_7000;
    #1;
    checks++;
    if (enable_tlb_write_o !== 1'b1 || virtual_page_o !== 20'h00403 || phys_page_o !== 20'h00007) begin
      errors++;
      $display("FAIL tlb_write en=%b vp=%h pp=%h exp 1 00403 00007",
               enable_tlb_write_o, virtual_page_o, phys_page_o);
    end
    stall = 1'b1;
    #1;
    checks++;
    if (enable_tlb_write_o !== 1'b0) begin
      errors++;
      $display("FAIL tlb_stalled en=%b exp 0", enable_tlb_write_o);
    end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_priv();
    clear_inputs();
    valid_i = 1'b1; tlbwrite_i = 1'b1; privilege = 1'b0;
    reg_write_i = 1'b1; mem_write_i = 1'b1;
    #1;
    checks++;
    if (enable_tlb_write_o !== 1'b0) begin
      errors++;
      $display("FAIL tlb_user_en en=%b exp 0", enable_tlb_write_o);
    end
    tick();
    checks++;
    if (exception !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL tlb_user_exc exc=%b rw=%b mw=%b exp 1 0 0", exception, reg_write, mem_write);
    end
    tlbwrite_i = 1'b0; iret_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h4000;
    tick();
    checks++;
    if (exception !== 1'b1 || pcSrc !== 1'b0) begin
      errors++;
      $display("FAIL iret_user exc=%b pcSrc=%b exp 1 0", exception, pcSrc);
    end
  endtask

  task automatic test_stall_bubble();
    exmem_t held;
    clear_inputs();
    valid_i = 1'b1; alu_op_i = 3'b001; reg_a_i = 32'd9; reg_b_i = 32'd4;
    reg_write_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h200;
    tick();
    checks++;
    if (alu_result !== 32'd5 || pcSrc !== 1'b1) begin
      errors++;
      $display("FAIL sub_load alu=%h pcSrc=%b exp 5 1", alu_result, pcSrc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      tick();
      checks++;
      if (alu_result !== 32'd5 || pcSrc !== 1'b1 || valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d alu=%h pcSrc=%b valid=%b exp 5 1 1",
                 i, alu_result, pcSrc, valid);
      end
    end
    stall = 1'b0; bubble = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || reg_write !== 1'b0 || pcSrc !== 1'b0 || alu_result !== 32'd0) begin
      errors++;
      $display("FAIL bubble valid=%b rw=%b pcSrc=%b alu=%h exp 0 0 0 0",
               valid, reg_write, pcSrc, alu_result);
    end
    bubble = 1'b0;
    random_inputs();
    valid_i = 1'b1;
    tick();
    held = exp_q;
    stall = 1'b1; bubble = 1'b1;
    random_inputs();
    tick();
    checks++;
    if (got !== held) begin
      errors++;
      $display("FAIL stall_bubble_hold got=%h exp=%h", got, held);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall got=%h exp=0", got);
    end
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      rst    = ($urandom_range(0, 31) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      bubble = ($urandom_range(0, 4) == 0);
      #1;
      checks++;
      if (enable_tlb_write_o !== (valid_i && tlbwrite_i && privilege && !stall) ||
          virtual_page_o !== reg_a_i[31:12] || phys_page_o !== reg_b_i[31:12]) begin
        errors++;
        $display("FAIL rand_tlb iter=%0d en=%b vp=%h pp=%h a=%h b=%h",
                 i, enable_tlb_write_o, virtual_page_o, phys_page_o, reg_a_i, reg_b_i);
      end
      tick();
      checks++;
      if (got !== exp_q) begin
        errors++;
        $display("FAIL rand_exmem iter=%0d got=%h exp=%h", i, got, exp_q);
      end
    end
    rst = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  initial begin
    exp_q = '0;
    rst = 1'b1; stall = 1'b0; bubble = 1'b0;
    clear_inputs();
    test_reset();
    test_add();
    test_branch();
    test_tlb();
    test_priv();
    test_stall_bubble();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
